zero_indices_sched: RTL and testbench
=====================================

# zero_indices_sched

Shared zero-index enumeration scheduler. N requesters each present a W-bit occupancy vector over a valid/ready handshake. A round-robin arbiter grants one requester at a time and captures its vector. The block then streams the index of every zero bit, lowest first, one per accepted response beat, tagged with the requester id, and signals a per-request completion. It sits between slot-owning clients and the resource allocator, so several clients can share a single enumeration engine.

## Interface
- W, 32, vector width; must be ≥2.
- N, 4, number of requesters; must be ≥2.
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N  request pending from requester i.
- req_vector  in  N*W  requester i vector at [i*W +: W]; 1 = occupied, 0 = report.
- req_ready  out  N  one-hot grant; transfer when req_valid[i] & req_ready[i].
- resp_valid  out  1  response beat available.
- resp_ready  in  1  consumer accepts beat.
- resp_index  out  $clog2(W)  index of current lowest zero.
- resp_id  out  $clog2(N)  id of requester being served.
- resp_last  out  1  present only with ZIS_LAST_EN; final beat of request.
- cmpl_valid  out  1  single-cycle pulse: a request has finished.
- cmpl_id  out  $clog2(N)  id of finished request; valid with cmpl_valid.
- busy_r  out  1  state is ENUM.

## Operation
- States: IDLE, ENUM. Reset state is IDLE.
- IDLE:
  - If any req_valid is set, pick the winner by round-robin, starting at ptr_r.
  - Assert req_ready[winner] combinationally in the same cycle. req_ready may depend on req_valid.
  - Capture vector_r and id_r. Set ptr_r to (winner+1) mod N.
  - If the captured vector is all ones, stay in IDLE and pulse cmpl for the winner. No response beats are issued.
  - Otherwise go to ENUM.
- IDLE with no req_valid: req_ready = 0 and state holds.
- ENUM:
  - resp_valid = 1.
  - resp_index = encode(lowest zero of vector_r).
  - resp_id = id_r.
  - req_ready = 0.
- ENUM, on resp_valid & resp_ready:
  - Set the reported bit in vector_r.
  - If the updated vector is all ones, go to IDLE and pulse cmpl with id_r.
- ENUM without handshake: resp_index, resp_id and resp_last hold stable, and resp_valid stays high. Backpressure never skips or repeats an index.
- When resp_valid is 0, resp_index and resp_id drive 0.
- Index arithmetic:
  - Indices ascend strictly within one request.
  - The beat count equals the number of zeros in the captured vector, between 1 and W.
- Fairness: ptr_r advances only on a grant. A continuously requesting client waits at most N-1 other requests.
- Vector changes on non-granted requesters are ignored until their grant.

## Timing
- Grant at cycle T gives first resp_valid at T+1.
- Back-to-back beats: one index per cycle while resp_ready = 1.
- Last handshake at cycle T:
  - cmpl_valid at T+1 (registered).
  - busy_r = 0 at T+1.
  - The next grant can occur at T+1, giving its first beat at T+2.
- All-ones grant at T: cmpl_valid at T+1. The next grant can occur at T+1.
- Reset, asynchronous, any time including mid-enumeration:
  - state goes to IDLE.
  - resp_valid, req_ready, cmpl_valid, busy_r and resp_last go to 0 immediately.
  - ptr_r goes to 0, so requester 0 has highest priority.
  - The in-flight request is discarded.
  - vector_r and id_r are reset to 0.
- Reset values of every output:
  - req_ready 0, resp_valid 0, resp_index 0, resp_id 0.
  - resp_last 0, cmpl_valid 0, cmpl_id 0, busy_r 0.

## Configuration
- ZIS_LAST_EN defined:
  - resp_last port exists.
  - resp_last = resp_valid & (vector_r has exactly one zero).
  - Implemented as a one-hot check on ~vector_r.
- ZIS_LAST_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- N=4, W=8, req_valid=0001, req_vector[7:0]=8'b1010_0110, resp_ready=1 -> grant at T; beats at T+1..T+4.
  - Indices 0, 3, 4, 6, all with resp_id 0.
  - resp_last only on index 6 (ZIS_LAST_EN).
  - cmpl_valid with cmpl_id 0 at T+5.
- Same vector with resp_ready low for 3 cycles while index 3 is presented -> resp_index stays 3 and resp_valid stays high; sequence resumes with 4, 6 and no skip.
- Requester 2 only, vector 8'hFF -> req_ready=0100 for one cycle, no resp_valid, cmpl_valid with cmpl_id 2 next cycle.
- All four req_valid held high, each vector 8'hFE -> grant order 0,1,2,3,0. Each request yields a single beat with index 0 and the matching resp_id.
- Vector 8'h00, resp_ready=1 -> 8 beats with indices 0..7, resp_last on 7, then one cmpl pulse.
- rst asserted mid-enumeration of requester 1 -> resp_valid and busy_r drop without waiting for a clock. After release with req_valid=1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/zero_indices_sched.sv
// Shared zero-index enumeration scheduler: round-robin grant, then one beat per zero bit, lowest first.
// Optional feature macro: ZIS_LAST_EN adds the resp_last port (final beat of a request).
module zero_indices_sched #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_vector,
  output logic [N-1:0]         req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [$clog2(W)-1:0] resp_index,
  output logic [$clog2(N)-1:0] resp_id,
`ifdef ZIS_LAST_EN
  output logic                 resp_last,
`endif
  output logic                 cmpl_valid,
  output logic [$clog2(N)-1:0] cmpl_id,
  output logic                 busy_r
);

  localparam int IW = $clog2(W);
  localparam int NW = $clog2(N);

  typedef enum logic {IDLE, ENUM} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] ptr_q, ptr_d;
  logic [NW-1:0] id_q, id_d;
  logic [W-1:0]  vector_q, vector_d;
  logic          cmpl_valid_q, cmpl_valid_d;
  logic [NW-1:0] cmpl_id_q, cmpl_id_d;

  logic          win_found;
  logic [NW-1:0] win_id;
  logic [W-1:0]  win_vector;
  logic [IW-1:0] low_idx;
  logic [W-1:0]  vec_set;

  // Round-robin search: first valid requester at or after ptr_q, wrapping at N.
  always_comb begin
    int cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N) cand = cand - N;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = NW'(cand);
      end
    end
  end

  assign win_vector = req_vector[int'(win_id)*W +: W];

  // Downward scan so the last hit is the lowest zero.
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!vector_q[i]) low_idx = IW'(i);
    end
  end

  assign vec_set = vector_q | (W'(1) << low_idx);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    vector_d     = vector_q;
    cmpl_valid_d = 1'b0;
    cmpl_id_d    = cmpl_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          ptr_d    = (win_id == NW'(N - 1)) ? '0 : win_id + 1'b1;
          id_d     = win_id;
          vector_d = win_vector;
          // A fully occupied vector has nothing to report: complete without any beat.
          if (&win_vector) begin
            cmpl_valid_d = 1'b1;
            cmpl_id_d    = win_id;
          end else begin
            state_d = ENUM;
          end
        end
      end
      ENUM: begin
        if (resp_ready) begin
          vector_d = vec_set;
          if (&vec_set) begin
            state_d      = IDLE;
            cmpl_valid_d = 1'b1;
            cmpl_id_d    = id_q;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      vector_q     <= '0;
      cmpl_valid_q <= 1'b0;
      cmpl_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      vector_q     <= vector_d;
      cmpl_valid_q <= cmpl_valid_d;
      cmpl_id_q    <= cmpl_id_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) req_ready[win_id] = 1'b1;
  end

  assign busy_r     = (state_q == ENUM);
  assign resp_valid = busy_r;
  assign resp_index = busy_r ? low_idx : '0;
  assign resp_id    = busy_r ? id_q : '0;
  assign cmpl_valid = cmpl_valid_q;
  assign cmpl_id    = cmpl_id_q;

`ifdef ZIS_LAST_EN
  logic [W-1:0] zeros;
  assign zeros     = ~vector_q;
  // One-hot test on the remaining zeros: exactly one left means this beat is the last.
  assign resp_last = busy_r && (zeros != '0) && ((zeros & (zeros - 1'b1)) == '0);
`endif

endmodule

// File: tb/tb_zero_indices_sched.sv
// Self-checking bench for zero_indices_sched (W=8, N=4): directed table, hand sequences, random vs queue model.
module tb_zero_indices_sched;

  localparam int W = 8;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_vector = '0;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [2:0]      resp_index;
  logic [1:0]      resp_id;
  logic            resp_last;
  logic            cmpl_valid;
  logic [1:0]      cmpl_id;
  logic            busy_r;

  int checks = 0;
  int errors = 0;

  zero_indices_sched #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_vector (req_vector),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_index (resp_index),
    .resp_id    (resp_id),
`ifdef ZIS_LAST_EN
    .resp_last  (resp_last),
`endif
    .cmpl_valid (cmpl_valid),
    .cmpl_id    (cmpl_id),
    .busy_r     (busy_r)
  );

`ifndef ZIS_LAST_EN
  assign resp_last = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] vec;
    logic        rr;
    logic [3:0]  e_ready;
    logic        e_rv;
    logic [2:0]  e_idx;
    logic [1:0]  e_id;
    logic        e_last;
    logic        e_cmpl;
    logic [1:0]  e_cid;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] rv, logic [31:0] vec, logic rr, logic [3:0] er,
                              logic erv, logic [2:0] ei, logic [1:0] eid, logic el,
                              logic ec, logic [1:0] ecid, logic eb);
    vec_t v;
    v.rv = rv; v.vec = vec; v.rr = rr; v.e_ready = er; v.e_rv = erv; v.e_idx = ei;
    v.e_id = eid; v.e_last = el; v.e_cmpl = ec; v.e_cid = ecid; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_ready, input logic e_rv,
                            input logic [2:0] e_idx, input logic [1:0] e_id, input logic e_last,
                            input logic e_cmpl, input logic [1:0] e_cid, input logic e_busy);
    check({tag, " req_ready"}, 32'(req_ready), 32'(e_ready));
    check({tag, " resp_valid"}, 32'(resp_valid), 32'(e_rv));
    check({tag, " resp_index"}, 32'(resp_index), 32'(e_idx));
    check({tag, " resp_id"}, 32'(resp_id), 32'(e_id));
`ifdef ZIS_LAST_EN
    check({tag, " resp_last"}, 32'(resp_last), 32'(e_last));
`endif
    check({tag, " cmpl_valid"}, 32'(cmpl_valid), 32'(e_cmpl));
    if (e_cmpl) check({tag, " cmpl_id"}, 32'(cmpl_id), 32'(e_cid));
    check({tag, " busy_r"}, 32'(busy_r), 32'(e_busy));
  endtask

  task automatic drive(input logic [3:0] rv, input logic [31:0] vec, input logic rr);
    req_valid  = rv;
    req_vector = vec;
    resp_ready = rr;
  endtask

  // Inputs change at posedge+1; outputs are compared on the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: pending indices as a queue, grants by plain modular search.
  int  m_q[$];
  int  m_id, m_ptr, m_cid;
  bit  m_cmpl;

  task automatic run_random(input int cycles);
    logic [3:0]  rv;
    logic [31:0] vec;
    logic        rr;
    logic [3:0]  e_ready;
    bit          found;
    int          win, c;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      rv = 4'($urandom_range(0, 15));
      for (int r = 0; r < N; r++) begin
        case ($urandom_range(0, 3))
          0: vec[r*W +: W] = 8'hFF;
          1: vec[r*W +: W] = 8'($urandom);
          2: vec[r*W +: W] = 8'($urandom) | 8'($urandom);
          default: vec[r*W +: W] = 8'($urandom) | 8'($urandom) | 8'($urandom);
        endcase
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(rv, vec, rr);
      found = 1'b0;
      win = 0;
      e_ready = '0;
      if (m_q.size() == 0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!found && rv[c]) begin
            found = 1'b1;
            win = c;
          end
        end
        if (found) e_ready[win] = 1'b1;
      end
      @(negedge clk);
      if (m_q.size() > 0)
        check_outs("rand", e_ready, 1'b1, 3'(m_q[0]), 2'(m_id), m_q.size() == 1,
                   m_cmpl, 2'(m_cid), 1'b1);
      else
        check_outs("rand", e_ready, 1'b0, 3'd0, 2'd0, 1'b0, m_cmpl, 2'(m_cid), 1'b0);
      @(posedge clk);
      m_cmpl = 1'b0;
      if (m_q.size() > 0) begin
        if (rr) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_cmpl = 1'b1;
            m_cid  = m_id;
          end
        end
      end else if (found) begin
        m_id  = win;
        m_ptr = (win + 1) % N;
        for (int b = 0; b < W; b++) if (!vec[win*W + b]) m_q.push_back(b);
        if (m_q.size() == 0) begin
          m_cmpl = 1'b1;
          m_cid  = win;
        end
      end
      #1;
    end
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state, checked while reset is held and before any clock edge.
    #1 rst = 1'b1;
    #2;
    check_outs("reset", 4'b0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    check("reset cmpl_id", 32'(cmpl_id), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed table: basic stream, backpressure on index 3, all-ones request from requester 2.
    tbl.push_back(mk(4'b0001, 32'h000000A6, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 6, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'b0001, 32'h000000A6, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        0, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 1, 6, 0, 1, 0, 0, 1));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(4'b0100, 32'h00FF0000, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 0, 0, 0, 0, 1, 2, 0));
    tbl.push_back(mk(4'b0000, 32'h0,        1, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rv, tbl[i].vec, tbl[i].rr);
      @(negedge clk);
      check_outs($sformatf("tbl%0d", i), tbl[i].e_ready, tbl[i].e_rv, tbl[i].e_idx,
                 tbl[i].e_id, tbl[i].e_last, tbl[i].e_cmpl, tbl[i].e_cid, tbl[i].e_busy);
      next_cycle();
    end

    // All four requesting 8'hFE: grant order 0,1,2,3,0, one index-0 beat each.
    do_reset();
    drive(4'b1111, 32'hFEFEFEFE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outs($sformatf("rr_grant%0d", i), 4'(1 << order[i]), 1'b0, 3'd0, 2'd0, 1'b0,
                 i > 0, 2'(i > 0 ? order[i-1] : 0), 1'b0);
      next_cycle();
      @(negedge clk);
      check_outs($sformatf("rr_beat%0d", i), 4'b0000, 1'b1, 3'd0, 2'(order[i]), 1'b1,
                 1'b0, 2'd0, 1'b1);
      next_cycle();
    end
    drive(4'b0000, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("rr_cmpl", 4'b0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0);
    next_cycle();

    // Vector 8'h00 on requester 1: eight beats 0..7, last on 7, one completion.
    drive(4'b0010, 32'h0, 1'b1);
    @(negedge clk);
    check_outs("full_grant", 4'b0010, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0);
    next_cycle();
    drive(4'b0000, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_outs($sformatf("full_beat%0d", i), 4'b0000, 1'b1, 3'(i), 2'd1, i == 7,
                 1'b0, 2'd0, 1'b1);
      next_cycle();
    end
    @(negedge clk);
    check_outs("full_cmpl", 4'b0000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0);
    next_cycle();
    @(negedge clk);
    check("full_single_pulse", 32'(cmpl_valid), 32'd0);
    next_cycle();

    // Reset mid-enumeration of requester 1, asserted between clock edges.
    drive(4'b0010, 32'h0, 1'b1);
    next_cycle();
    drive(4'b0000, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check("midrst pre resp_index", 32'(resp_index), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    check("midrst busy_r", 32'(busy_r), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(4'b1111, 32'hFEFEFEFE, 1'b1);
    @(negedge clk);
    check("midrst first grant", 32'(req_ready), 32'b0001);
    next_cycle();

    // Randomized traffic against the queue model, starting from reset.
    do_reset();
    m_q.delete();
    m_id = 0; m_ptr = 0; m_cid = 0; m_cmpl = 1'b0;
    run_random(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
